// File: rtl/struct_s.sv
// Shared stats-channel definitions: the {addr, val} word carried on stats
// streams and the well-known register addresses.
package struct_s;

  localparam int STATS_ADDR_W = 8;

  typedef struct packed {
    logic [STATS_ADDR_W-1:0] addr;
    logic [31:0]             val;
  } stats_t;

  localparam logic [STATS_ADDR_W-1:0] REG_RX_PKTS  = 8'h00;
  localparam logic [STATS_ADDR_W-1:0] REG_TX_PKTS  = 8'h01;
  localparam logic [STATS_ADDR_W-1:0] REG_RX_BYTES = 8'h02;
  localparam logic [STATS_ADDR_W-1:0] REG_TX_BYTES = 8'h03;
  localparam logic [STATS_ADDR_W-1:0] REG_ERRORS   = 8'h04;
  localparam logic [STATS_ADDR_W-1:0] REG_NOTUSED  = 8'h3F;

endpackage

// File: rtl/stats_regfile.sv
// Simple dual-port NUM_REGS x 32 RAM: one write port, one registered read port.
module stats_regfile #(
  parameter int NUM_REGS = 64,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             Clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [NUM_REGS];
  logic [31:0] rdata_q;

  always_ff @(posedge Clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/stats_collector_avlstrm.sv
// Stats channel endpoint: keeps the latest value per address, with a CSR read
// port, a clear sweep and saturating update/drop counters.
module stats_collector_avlstrm
  import struct_s::*;
#(
  parameter int                      NUM_REGS  = 64,
  parameter logic [STATS_ADDR_W-1:0] DROP_ADDR = REG_NOTUSED
) (
  input  logic                      Clk,
  input  logic                      Rst,
  // stats_in: a word transfers on a rising edge where valid and ready are both
  // high; the source holds data stable while valid is high and ready is low.
  input  logic                      stats_in_valid,
  output logic                      stats_in_ready,
  input  logic [$bits(stats_t)-1:0] stats_in_data,
  input  logic                      clear,
  output logic                      busy,
  input  logic                      rd_en,
  input  logic [STATS_ADDR_W-1:0]   rd_addr,
  output logic                      rd_valid,
  output logic [31:0]               rd_data,
  output logic [31:0]               upd_cnt,
  output logic [31:0]               drop_cnt,
  output logic                      dbg_state
);

  localparam int                    IDX_W      = $clog2(NUM_REGS);
  localparam int                    AW1        = STATS_ADDR_W + 1;
  localparam logic [AW1-1:0]        NUM_REGS_A = AW1'(NUM_REGS);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_REGS - 1);

  typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               wr_vld_q, wr_vld_d;
  logic [IDX_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]        wr_val_q, wr_val_d;
  logic [31:0]        upd_q, upd_d, drop_q, drop_d;
  logic               rd_valid_q, rd_zero_q, rd_zero_d, rd_fwd_q, rd_fwd_d;
  logic [31:0]        rd_fwd_val_q;
  stats_t             word;
  logic               accept, is_drop;
  logic               ram_we;
  logic [IDX_W-1:0]   ram_waddr;
  logic [31:0]        ram_wdata, ram_rdata;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign word           = stats_t'(stats_in_data);
  assign stats_in_ready = (state_q == RUN) && !clear;
  assign accept         = stats_in_valid && stats_in_ready;
  assign is_drop        = (word.addr == DROP_ADDR) || ({1'b0, word.addr} >= NUM_REGS_A);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      SWEEP: begin
        if (clear) begin
          idx_d = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RUN: begin
        if (clear) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  always_comb begin
    wr_vld_d  = accept && !is_drop;
    wr_addr_d = word.addr[IDX_W-1:0];
    wr_val_d  = word.val;
    upd_d     = upd_q;
    drop_d    = drop_q;
    if ((state_q == RUN) && clear) begin
      upd_d  = '0;
      drop_d = '0;
    end else if (accept) begin
      if (is_drop) drop_d = sat_inc(drop_q);
      else         upd_d  = sat_inc(upd_q);
    end
  end

  // Reads forward the write-stage value committing on the same edge, since the
  // RAM's registered read would still see the old contents.
  always_comb begin
    rd_zero_d = (state_q == SWEEP) || ({1'b0, rd_addr} >= NUM_REGS_A);
    rd_fwd_d  = wr_vld_q && (wr_addr_q == rd_addr[IDX_W-1:0]);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= SWEEP;
      idx_q      <= '0;
      wr_vld_q   <= 1'b0;
      upd_q      <= '0;
      drop_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
      rd_fwd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_vld_q   <= wr_vld_d;
      upd_q      <= upd_d;
      drop_q     <= drop_d;
      rd_valid_q <= rd_en;
      rd_zero_q  <= rd_zero_d;
      rd_fwd_q   <= rd_fwd_d;
    end
    wr_addr_q    <= wr_addr_d;
    wr_val_q     <= wr_val_d;
    rd_fwd_val_q <= wr_val_q;
  end

  // Reset drops a pending write-stage commit; the restarted sweep owns the port.
  assign ram_we    = !Rst && ((state_q == SWEEP) || wr_vld_q);
  assign ram_waddr = (state_q == SWEEP) ? idx_q : wr_addr_q;
  assign ram_wdata = (state_q == SWEEP) ? 32'd0 : wr_val_q;

  stats_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .Clk   (Clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr[IDX_W-1:0]),
    .rdata (ram_rdata)
  );

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_zero_q ? 32'd0 : (rd_fwd_q ? rd_fwd_val_q : ram_rdata);
  assign busy      = (state_q == SWEEP);
  assign upd_cnt   = upd_q;
  assign drop_cnt  = drop_q;
  assign dbg_state = state_q;

endmodule

// File: doc/stats_collector_avlstrm.md
# stats_collector_avlstrm

Receive-side endpoint for the stats channel. It consumes the `stats_t` {addr, val} words that the per-service stats packers serialise onto `stats_out` streams, and maintains a register file of the latest value per address. It exposes a 1-cycle CSR read port, a clear command, and update/drop counters. It sits at the top of the pipeline, where the service stats streams converge (after any arbiter/mux), and feeds the host-visible CSR block.

## Interface
- `NUM_REGS`, default 64: number of register-file entries. Valid addresses are 0..NUM_REGS-1. Must be a power of 2 and ≤ 2^`STATS_ADDR_W`.
- `DROP_ADDR`, default `REG_NOTUSED`: address whose words are accepted and discarded.
- `Clk`, in, 1: single clock.
- `Rst`, in, 1: synchronous, active-high reset.
- `stats_in`, `avl_stream_if.rx`, `$bits(stats_t)`: incoming stats words. Only `valid`, `ready` and `data` are used; `sop`, `eop` and `empty` are ignored.
- `clear`, in, 1: single-cycle request to zero all entries and both counters.
- `busy`, out, 1: high while a clear sweep is running.
- `rd_en`, in, 1: CSR read strobe.
- `rd_addr`, in, `STATS_ADDR_W`: CSR read address.
- `rd_valid`, out, 1: read data valid, one cycle after `rd_en`.
- `rd_data`, out, 32: read data.
- `upd_cnt`, out, 32: number of words written into the register file.
- `drop_cnt`, out, 32: number of words discarded (`DROP_ADDR` or out of range).

## Operation
- FSM states are SWEEP and RUN.
  - `Rst` forces SWEEP with index 0.
  - SWEEP writes 0 to entry[index], one entry per cycle. After entry NUM_REGS-1 it moves to RUN, so a sweep takes NUM_REGS cycles.
  - In RUN, `clear`=1 moves to SWEEP with index 0 and zeroes both counters in the same edge.
  - `clear` asserted during SWEEP restarts the index at 0.
- `stats_in.ready` = (state==RUN) && !`clear`. Handshake completes when valid && ready are both high at a rising edge.
- Word classification for an accepted word:
  - addr == `DROP_ADDR`: `drop_cnt`++.
  - addr ≥ NUM_REGS: `drop_cnt`++.
  - Otherwise the word enters a one-entry write stage and `upd_cnt`++.
- The write stage commits to the RAM one edge after acceptance. Back-to-back words to the same address follow last-writer-wins.
- Both counters saturate at 0xFFFF_FFFF and do not wrap.
- Reads:
  - `rd_addr` ≥ NUM_REGS returns 0.
  - Reads during SWEEP return 0.
  - A read sampled in the same edge as a pending write-stage commit to the same address returns the new value through forwarding.
  - A read that coincides with word acceptance returns the prior value.
- `busy` = (state==SWEEP).

## Timing
- Reset values: `stats_in.ready`=0, `busy`=1, `rd_valid`=0, `rd_data`=0, `upd_cnt`=0, `drop_cnt`=0, write stage empty.
- The first `ready`=1 occurs NUM_REGS cycles after `Rst` deasserts.
- Write latency: a word accepted at edge T is visible to a read sampled at edge T+1 or later. Read latency is 1: `rd_en` at edge R gives `rd_valid`/`rd_data` after R, held for one cycle.
- Throughput: 1 word/cycle and 1 read/cycle concurrently in RUN.
- `Rst` mid-operation discards the write stage and restarts the sweep.
- `clear` coinciding with a valid input word does not accept the word, because ready is low in that cycle.

## Structure
- Shared package `struct_s`, reused unchanged: `stats_t`, `STATS_ADDR_W`, and the `REG_*` address constants including `REG_NOTUSED`.
- Sub-module `stats_regfile`: simple dual-port NUM_REGS×32 RAM with 1 write port and 1 registered read port. The forwarding mux stays in the top level.
- The FSM, classifier, write stage and saturating counters stay in `stats_collector_avlstrm`.

## Test plan
- **Reset sweep:** deassert `Rst`, hold valid=1. `ready` stays 0 for 64 cycles. All 64 reads return 0; counters = 0.
- **Basic update:** send {addr=5, val=0x1234}, then read addr 5 one cycle later. `rd_data`=0x1234 via forwarding, `upd_cnt`=1.
- **Drops:** send one word each to `REG_NOTUSED`, addr 200 and addr 3. Expect `drop_cnt`=2, `upd_cnt`=1; a read of addr 200 returns 0.
- **Last-writer-wins:** send back-to-back {7,0xA} then {7,0xB}. A read of addr 7 returns 0xB; `upd_cnt`=2.
- **Clear under traffic:** pulse `clear` while valid=1 streams continuously. `ready` goes low for 65 cycles (the clear cycle plus the sweep), counters go to 0, all entries read 0, and the stream then resumes without any word being lost.
- **Saturation:** force `upd_cnt`=0xFFFF_FFFE and send 3 valid words. `upd_cnt` stays at 0xFFFF_FFFF.
